vm_write_arbiter: RTL and testbench
===================================

VM_WRITE_ARBITER -- requirements
Module: vm_write_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: number of buffered CPU write entries; a power of two, at least 2.
REQ-002 Parameter CLR_WORDS, default 4096: number of video-memory words written by one clear operation.
REQ-003 Port clk_50mhz, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port cpu_we, input, 1 bit: CPU write strobe, driven from Memwrite[0].
REQ-006 Port cpu_addr, input, 12 bits: CPU write address in video memory.
REQ-007 Port cpu_data, input, 8 bits: CPU write character, driven from BUS[7:0].
REQ-008 Port cpu_ready, output, 1 bit: high when a cpu_we in this cycle will be accepted.
REQ-009 Port clr_req, input, 1 bit: single-cycle pulse requesting a screen clear.
REQ-010 Port fill_char, input, 8 bits: character written by a clear, sampled on the cycle clr_req is accepted.
REQ-011 Port clr_busy, output, 1 bit: high from clr_req acceptance until the last clear write is issued.
REQ-012 Port vm_we, output, 1 bit: registered write enable to VM port A.
REQ-013 Port vm_addr, output, 12 bits: registered write address to VM port A.
REQ-014 Port vm_din, output, 8 bits: registered write data to VM port A.

Function
REQ-015 A CPU write SHALL be accepted on any cycle where cpu_we and cpu_ready are both high, and pushed into the FIFO as {cpu_addr, cpu_data}.
REQ-016 cpu_we while cpu_ready is low SHALL be dropped with no effect.
REQ-017 The FSM SHALL have three states: IDLE, DRAIN and CLEAR.
REQ-018 In IDLE with the FIFO non-empty, the arbiter SHALL pop one entry per cycle and issue it on vm_* in the next cycle.
REQ-019 A write accepted into an empty FIFO in IDLE SHALL appear on vm_we exactly 2 cycles after acceptance, giving a sustained throughput of 1 write per cycle.
REQ-020 On clr_req in IDLE: if the FIFO is empty (after any same-cycle push), the FSM SHALL go to CLEAR; otherwise it SHALL go to DRAIN.
REQ-021 A cpu_we and clr_req in the same cycle SHALL accept the CPU write first, so the FSM goes to DRAIN.
REQ-022 In DRAIN, cpu_ready SHALL be 0 and the FIFO SHALL pop one entry per cycle; the FSM SHALL move to CLEAR on the cycle after the last pop.
REQ-023 In CLEAR, the arbiter SHALL issue vm_we=1, vm_din=fill_char latch, and vm_addr=0,1,...,CLR_WORDS-1 on consecutive cycles, then return to IDLE.
REQ-024 In CLEAR, cpu_ready SHALL equal !full; accepted writes SHALL be held in the FIFO and committed after the clear, in arrival order.
REQ-025 In IDLE and DRAIN, cpu_ready SHALL equal !full in IDLE and 0 in DRAIN.
REQ-026 clr_req received in DRAIN or CLEAR SHALL be ignored.
REQ-027 vm_we SHALL be 0 on any cycle with no pop and no clear write.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit.
REQ-029 The clear counter SHALL be 12 bits wide and SHALL not wrap past CLR_WORDS-1.

Reset
REQ-030 While rst_n=0 at a clock edge, the following SHALL hold: FSM=IDLE, FIFO empty, clear counter=0, vm_we=0, vm_addr=0, vm_din=0, clr_busy=0, cpu_ready=0.
REQ-031 cpu_ready SHALL rise on the first cycle after reset release.
REQ-032 A reset asserted during CLEAR or DRAIN SHALL abort the operation and discard all FIFO contents.

Configuration
REQ-033 With macro VM_ARB_CLEAR_EN defined, the clear engine SHALL be compiled in as specified above.
REQ-034 Without VM_ARB_CLEAR_EN: clr_req SHALL be ignored, clr_busy SHALL be tied to 0, the CLEAR and DRAIN states SHALL not exist, and only the FIFO drain path SHALL remain.

Structure
REQ-035 Package vga_pkg SHALL hold the constants VM_ADDR_W=12 and VM_DATA_W=8, the FSM state enum, and the FIFO entry typedef.
REQ-036 The FIFO SHALL be a sub-module named vm_wr_fifo, providing push, pop, full and empty.

Verification
REQ-037 Reset, then write cpu_we addr=0x005 data=0x41 -> vm_we=1, vm_addr=0x005, vm_din=0x41 exactly 2 cycles later, for a single cycle.
REQ-038 Issue 6 back-to-back writes during CLEAR with FIFO_DEPTH=4 -> cpu_ready drops after the 4th write, the 5th and 6th are dropped, and the 4 accepted writes are committed in order after address 4095.
REQ-039 clr_req with fill_char=0x20 and an empty FIFO -> clr_busy=1, then 4096 consecutive writes of 0x20 to addresses 0..4095, then IDLE.
REQ-040 Push 3 writes, then clr_req -> the 3 writes are committed first, cpu_ready=0 throughout DRAIN, then the clear starts.
REQ-041 Assert rst_n=0 at clear address 100 -> vm_we=0 on the next cycle; a subsequent write commits with normal 2-cycle latency.
REQ-042 Build without VM_ARB_CLEAR_EN, then pulse clr_req -> no vm_we activity and clr_busy stays 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and types for the video-memory write arbiter.
// The FSM encoding depends on VM_ARB_CLEAR_EN (clear engine compiled in or not).
package vga_pkg;

   localparam int unsigned VM_ADDR_W = 12;
   localparam int unsigned VM_DATA_W = 8;

`ifdef VM_ARB_CLEAR_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_CLEAR = 2'd2
   } vm_state_e;
`else
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0
   } vm_state_e;
`endif

   typedef struct packed {
      logic [VM_ADDR_W-1:0] addr;
      logic [VM_DATA_W-1:0] data;
   } vm_entry_t;

endpackage

// File: rtl/vm_wr_fifo.sv
// Small FIFO buffering CPU writes; pointers carry an extra wrap bit so that
// full and empty can be told apart without a separate counter register.
module vm_wr_fifo
   import vga_pkg::*;
#(
   parameter int unsigned DEPTH = 4
)(
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 i_push,
   input  vm_entry_t                            i_din,
   input  logic                                 i_pop,
   output vm_entry_t                            o_dout_c,
   output logic                                 o_full_c,
   output logic                                 o_empty_c,
   output logic [$clog2(DEPTH):0]               o_count_c
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PTR_W:0] r_wptr;
   logic [PTR_W:0] r_rptr;
   vm_entry_t      r_mem [DEPTH];
   logic           w_do_push;
   logic           w_do_pop;

   assign o_empty_c = (r_wptr == r_rptr);
   assign o_full_c  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                      (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
   assign o_count_c = r_wptr - r_rptr;
   assign o_dout_c  = r_mem[r_rptr[PTR_W-1:0]];

   assign w_do_push = i_push & ~o_full_c;
   assign w_do_pop  = i_pop  & ~o_empty_c;

   // Pointer update; reset discards all buffered entries
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + (PTR_W+1)'(1);
         if (w_do_pop)  r_rptr <= r_rptr + (PTR_W+1)'(1);
      end
   end

   // Storage write; contents are don't-care until pushed
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr[PTR_W-1:0]] <= i_din;
   end

endmodule

// File: rtl/vm_write_arbiter.sv
// Arbitrates video-memory port A between buffered CPU writes and a
// full-screen clear engine. Define VM_ARB_CLEAR_EN to compile the clear
// engine in; without it only the FIFO drain path exists.
module vm_write_arbiter
   import vga_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CLR_WORDS  = 4096
)(
   input  logic        clk_50mhz,
   input  logic        rst_n,
   input  logic        cpu_we,
   input  logic [11:0] cpu_addr,
   input  logic [7:0]  cpu_data,
   output logic        cpu_ready,
   input  logic        clr_req,
   input  logic [7:0]  fill_char,
   output logic        clr_busy,
   output logic        vm_we,
   output logic [11:0] vm_addr,
   output logic [7:0]  vm_din
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic                 w_push;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_ready;
   logic [CNT_W-1:0]     w_count;
   vm_entry_t            w_din;
   vm_entry_t            w_dout;
   logic                 r_run;
   logic                 r_vm_we;
   logic [VM_ADDR_W-1:0] r_vm_addr;
   logic [VM_DATA_W-1:0] r_vm_din;

   assign w_din     = '{addr: cpu_addr, data: cpu_data};
   assign w_push    = cpu_we & w_ready;
   assign cpu_ready = w_ready;
   assign vm_we     = r_vm_we;
   assign vm_addr   = r_vm_addr;
   assign vm_din    = r_vm_din;

   vm_wr_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk_50mhz),
      .rst_n     (rst_n),
      .i_push    (w_push),
      .i_din     (w_din),
      .i_pop     (w_pop),
      .o_dout_c  (w_dout),
      .o_full_c  (w_full),
      .o_empty_c (w_empty),
      .o_count_c (w_count)
   );

   // Ready gate: low through reset, high from the first cycle after release
   always_ff @(posedge clk_50mhz) begin
      if (!rst_n) r_run <= 1'b0;
      else        r_run <= 1'b1;
   end

`ifdef VM_ARB_CLEAR_EN

   vm_state_e            r_state;
   vm_state_e            w_state_next;
   logic [VM_ADDR_W-1:0] r_clr_cnt;
   logic [VM_DATA_W-1:0] r_fill;
   logic                 r_clr_busy;
   logic                 w_clr_wr;
   logic                 w_clr_last;
   logic                 w_clr_acc;

   assign w_clr_last = (r_clr_cnt == VM_ADDR_W'(CLR_WORDS - 1));
   assign w_clr_acc  = clr_req & (r_state == ST_IDLE);
   assign clr_busy   = r_clr_busy;

   // FSM state register
   always_ff @(posedge clk_50mhz) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // Next state: a pending or same-cycle CPU write forces a drain before clear
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (clr_req) w_state_next = (w_push || !w_empty) ? ST_DRAIN : ST_CLEAR;
         end
         ST_DRAIN: begin
            if (w_empty || (w_count == CNT_W'(1))) w_state_next = ST_CLEAR;
         end
         ST_CLEAR: begin
            if (w_clr_last) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Per-state controls: pop source, clear write, CPU back-pressure
   always_comb begin
      w_pop    = 1'b0;
      w_clr_wr = 1'b0;
      w_ready  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_ready = r_run & ~w_full;
            w_pop   = ~w_empty;
         end
         ST_DRAIN: begin
            w_pop = ~w_empty;
         end
         ST_CLEAR: begin
            w_ready  = r_run & ~w_full;
            w_clr_wr = 1'b1;
         end
         default: begin
            w_pop = 1'b0;
         end
      endcase
   end

   // Clear address counter and fill character latch
   always_ff @(posedge clk_50mhz) begin
      if (!rst_n) begin
         r_clr_cnt <= '0;
         r_fill    <= '0;
      end else begin
         if (w_clr_acc) r_fill <= fill_char;
         if (w_clr_wr)  r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + VM_ADDR_W'(1);
      end
   end

   // Registered VM port A and busy flag
   always_ff @(posedge clk_50mhz) begin
      if (!rst_n) begin
         r_vm_we    <= 1'b0;
         r_vm_addr  <= '0;
         r_vm_din   <= '0;
         r_clr_busy <= 1'b0;
      end else begin
         r_vm_we    <= w_pop | w_clr_wr;
         r_clr_busy <= (w_state_next != ST_IDLE);
         if (w_clr_wr) begin
            r_vm_addr <= r_clr_cnt;
            r_vm_din  <= r_fill;
         end else if (w_pop) begin
            r_vm_addr <= w_dout.addr;
            r_vm_din  <= w_dout.data;
         end
      end
   end

`else

   logic w_unused_clr;

   assign w_unused_clr = ^{clr_req, fill_char, w_count, VM_ADDR_W'(CLR_WORDS - 1)};
   assign clr_busy     = 1'b0;
   assign w_ready      = r_run & ~w_full;
   assign w_pop        = ~w_empty;

   // Registered VM port A, fed only by the FIFO
   always_ff @(posedge clk_50mhz) begin
      if (!rst_n) begin
         r_vm_we   <= 1'b0;
         r_vm_addr <= '0;
         r_vm_din  <= '0;
      end else begin
         r_vm_we <= w_pop;
         if (w_pop) begin
            r_vm_addr <= w_dout.addr;
            r_vm_din  <= w_dout.data;
         end
      end
   end

`endif

endmodule

// File: tb/tb_vm_write_arbiter.sv
// Directed bench for vm_write_arbiter with a write scoreboard.
// Clear-engine scenarios are built only when VM_ARB_CLEAR_EN is defined.
module tb_vm_write_arbiter;
   import vga_pkg::*;

   logic        clk_50mhz = 1'b0;
   logic        rst_n     = 1'b0;
   logic        cpu_we    = 1'b0;
   logic [11:0] cpu_addr  = '0;
   logic [7:0]  cpu_data  = '0;
   logic        cpu_ready;
   logic        clr_req   = 1'b0;
   logic [7:0]  fill_char = '0;
   logic        clr_busy;
   logic        vm_we;
   logic [11:0] vm_addr;
   logic [7:0]  vm_din;

   int unsigned errors = 0;
   int unsigned checks = 0;
   vm_entry_t   exp_q[$];

   vm_write_arbiter #(
      .FIFO_DEPTH (4),
      .CLR_WORDS  (4096)
   ) dut (
      .clk_50mhz (clk_50mhz),
      .rst_n     (rst_n),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_data  (cpu_data),
      .cpu_ready (cpu_ready),
      .clr_req   (clr_req),
      .fill_char (fill_char),
      .clr_busy  (clr_busy),
      .vm_we     (vm_we),
      .vm_addr   (vm_addr),
      .vm_din    (vm_din)
   );

   always #10 clk_50mhz = ~clk_50mhz;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h required=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_50mhz);
      #1;
   endtask

   task automatic push_exp(input logic [11:0] a, input logic [7:0] d);
      vm_entry_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic push_clear(input logic [7:0] d);
      for (int a = 0; a < 4096; a++) push_exp(12'(a), d);
   endtask

   task automatic wait_drain(input string tag, input int max_cycles);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max_cycles) begin
         tick();
         n++;
      end
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   // Scoreboard: every VM write must match the oldest expected entry
   always @(negedge clk_50mhz) begin
      vm_entry_t e;
      if (vm_we === 1'b1) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_write observed addr=0x%0h din=0x%0h required none", vm_addr, vm_din);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_addr", 32'(vm_addr), 32'(e.addr));
            chk("sb_din",  32'(vm_din),  32'(e.data));
         end
      end
   end

   initial begin
      int n;

      // Reset state
      rst_n = 1'b0;
      repeat (3) tick();
      chk("rst_vm_we",     32'(vm_we),     32'd0);
      chk("rst_vm_addr",   32'(vm_addr),   32'd0);
      chk("rst_vm_din",    32'(vm_din),    32'd0);
      chk("rst_clr_busy",  32'(clr_busy),  32'd0);
      chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
      rst_n = 1'b1;
      chk("rel_ready_low", 32'(cpu_ready), 32'd0);
      tick();
      chk("rel_ready_high", 32'(cpu_ready), 32'd1);

      // Single write, 2-cycle latency, single-cycle pulse
      cpu_we = 1'b1; cpu_addr = 12'h005; cpu_data = 8'h41;
      push_exp(12'h005, 8'h41);
      tick();
      cpu_we = 1'b0;
      chk("lat_cycle1_we", 32'(vm_we), 32'd0);
      tick();
      chk("lat_we",   32'(vm_we),   32'd1);
      chk("lat_addr", 32'(vm_addr), 32'h005);
      chk("lat_din",  32'(vm_din),  32'h41);
      tick();
      chk("lat_pulse_end", 32'(vm_we), 32'd0);

      // Back-to-back writes sustain one per cycle without back-pressure
      for (int i = 0; i < 6; i++) begin
         cpu_we = 1'b1; cpu_addr = 12'(12'h200 + i); cpu_data = 8'(8'h10 + i);
         push_exp(cpu_addr, cpu_data);
         chk("burst_ready", 32'(cpu_ready), 32'd1);
         tick();
      end
      cpu_we = 1'b0;
      wait_drain("burst_drain", 20);

      // Sparse random writes
      for (int i = 0; i < 24; i++) begin
         cpu_we   = 1'($urandom_range(0, 1));
         cpu_addr = 12'($urandom);
         cpu_data = 8'($urandom);
         if (cpu_we) push_exp(cpu_addr, cpu_data);
         tick();
      end
      cpu_we = 1'b0;
      wait_drain("rand_drain", 20);

      // Reset discards a write still sitting in the FIFO
      cpu_we = 1'b1; cpu_addr = 12'h0AA; cpu_data = 8'h77;
      tick();
      cpu_we = 1'b0;
      rst_n  = 1'b0;
      tick();
      chk("rstfifo_we0", 32'(vm_we), 32'd0);
      tick();
      chk("rstfifo_we1",    32'(vm_we),     32'd0);
      chk("rstfifo_ready",  32'(cpu_ready), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("rstfifo_rel_ready", 32'(cpu_ready), 32'd1);
      repeat (3) tick();

`ifdef VM_ARB_CLEAR_EN
      // Clear with empty FIFO: 4096 contiguous writes then idle
      clr_req = 1'b1; fill_char = 8'h20;
      push_clear(8'h20);
      tick();
      clr_req = 1'b0; fill_char = 8'h00;
      chk("clr_busy_on",  32'(clr_busy),  32'd1);
      chk("clr_ready",    32'(cpu_ready), 32'd1);
      n = 0;
      while (!(vm_we && vm_addr == 12'hFFF) && n < 5000) begin
         tick();
         n++;
      end
      chk("clr_len",      32'(n),        32'd4096);
      chk("clr_busy_off", 32'(clr_busy), 32'd0);
      tick();
      chk("clr_end_we",   32'(vm_we),    32'd0);
      chk("clr_empty_q",  32'(exp_q.size()), 32'd0);

      // Pending writes plus same-cycle clr_req: drain first, then clear
      cpu_we = 1'b1; cpu_addr = 12'h301; cpu_data = 8'hA1; push_exp(cpu_addr, cpu_data); tick();
      cpu_addr = 12'h302; cpu_data = 8'hA2; push_exp(cpu_addr, cpu_data); tick();
      cpu_addr = 12'h303; cpu_data = 8'hA3; push_exp(cpu_addr, cpu_data);
      clr_req = 1'b1; fill_char = 8'h2A;
      push_clear(8'h2A);
      tick();
      clr_req = 1'b0;
      chk("drain_ready", 32'(cpu_ready), 32'd0);
      chk("drain_busy",  32'(clr_busy),  32'd1);
      cpu_addr = 12'hFFF; cpu_data = 8'hEE;
      tick();
      cpu_we = 1'b0;
      wait_drain("drain_clear", 5000);
      tick();

      // Writes during clear: four buffered, two dropped, late clr_req ignored
      clr_req = 1'b1; fill_char = 8'h2E;
      push_clear(8'h2E);
      tick();
      clr_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cpu_we = 1'b1; cpu_addr = 12'(12'h100 + i); cpu_data = 8'(8'h60 + i);
         chk("clrwr_ready", 32'(cpu_ready), (i < 4) ? 32'd1 : 32'd0);
         if (i < 4) push_exp(cpu_addr, cpu_data);
         tick();
      end
      cpu_we = 1'b0;
      clr_req = 1'b1; fill_char = 8'h55;
      tick();
      clr_req = 1'b0;
      chk("clrwr_full_ready", 32'(cpu_ready), 32'd0);
      wait_drain("clrwr_drain", 5000);
      tick();
      chk("clrwr_idle_we",   32'(vm_we),     32'd0);
      chk("clrwr_idle_busy", 32'(clr_busy),  32'd0);

      // Reset in the middle of a clear aborts it
      clr_req = 1'b1; fill_char = 8'h3C;
      push_clear(8'h3C);
      tick();
      clr_req = 1'b0;
      n = 0;
      while (!(vm_we && vm_addr == 12'd100) && n < 300) begin
         tick();
         n++;
      end
      chk("abort_reach100", 32'(vm_addr), 32'd100);
      rst_n = 1'b0;
      tick();
      exp_q.delete();
      chk("abort_we",    32'(vm_we),    32'd0);
      chk("abort_busy",  32'(clr_busy), 32'd0);
      rst_n = 1'b1;
      tick();
      cpu_we = 1'b1; cpu_addr = 12'h123; cpu_data = 8'h5A;
      push_exp(12'h123, 8'h5A);
      tick();
      cpu_we = 1'b0;
      chk("abort_lat_c1", 32'(vm_we), 32'd0);
      tick();
      chk("abort_lat_we",   32'(vm_we),   32'd1);
      chk("abort_lat_addr", 32'(vm_addr), 32'h123);
      chk("abort_lat_din",  32'(vm_din),  32'h5A);
      tick();
`else
      // Without the clear engine clr_req has no visible effect
      clr_req = 1'b1; fill_char = 8'h20;
      tick();
      clr_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("noclr_we",   32'(vm_we),    32'd0);
         chk("noclr_busy", 32'(clr_busy), 32'd0);
         tick();
      end
      chk("noclr_ready", 32'(cpu_ready), 32'd1);
`endif

      wait_drain("final_drain", 20);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
